burst_slot_buffer: RTL and testbench

- Parametrised successor to the single-beat dual-port buffer.
- Holds NUM_SLOTS slots. Each slot stores one BURST_LEN-beat burst of DATA_WIDTH bits.
- Manages its own slot allocation, fill/drain state and beat counters. No external pointers are needed.
- Sits between the PHY read-return path (write side) and the cache/frontend (read side). The frontend drains any completed slot by slot ID with valid/ready flow control.

---
 rtl/burst_slot_buffer_if.sv | 46 ++++
 rtl/burst_slot_buffer.sv | 171 +++++++++++++++++
 tb/tb_burst_slot_buffer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/burst_slot_buffer_if.sv
// Bundle of write-side, drain-request and read-side signals for burst_slot_buffer.
// BURST_SLOT_BUFFER_PARITY_EN adds err_inject and rd_parity_err.
interface burst_slot_buffer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_SLOTS  = 4
);
    localparam int unsigned SW = $clog2(NUM_SLOTS);

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [SW-1:0]         wr_slot_id;
    logic                  rd_req_valid;
    logic [SW-1:0]         rd_req_slot;
    logic                  rd_req_ready;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic [NUM_SLOTS-1:0]  full_mask;
    logic [SW:0]           free_count;
`ifdef BURST_SLOT_BUFFER_PARITY_EN
    logic                  err_inject;
    logic                  rd_parity_err;
`endif

    modport slave (
`ifdef BURST_SLOT_BUFFER_PARITY_EN
        input  err_inject,
        output rd_parity_err,
`endif
        input  wr_valid, wr_data, rd_req_valid, rd_req_slot, rd_ready,
        output wr_ready, wr_slot_id, rd_req_ready, rd_valid, rd_data, rd_last,
        output full_mask, free_count
    );

    modport master (
`ifdef BURST_SLOT_BUFFER_PARITY_EN
        output err_inject,
        input  rd_parity_err,
`endif
        output wr_valid, wr_data, rd_req_valid, rd_req_slot, rd_ready,
        input  wr_ready, wr_slot_id, rd_req_ready, rd_valid, rd_data, rd_last,
        input  full_mask, free_count
    );
endinterface

// File: rtl/burst_slot_buffer.sv
// Multi-slot burst buffer: self-allocating write FSM fills slots, read FSM drains a slot by ID.
// Optional per-beat parity under BURST_SLOT_BUFFER_PARITY_EN.
module burst_slot_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned BURST_LEN  = 8
) (
    input logic                clk,
    input logic                rst,
    burst_slot_buffer_if.slave bus
);
    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned BW = $clog2(BURST_LEN);
    localparam int unsigned CW = SW + 1;
    localparam logic [BW-1:0] LastBeat = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {SlotFree, SlotFilling, SlotFull, SlotDraining} slot_e;
    typedef enum logic {WIdle, WFill} wstate_e;
    typedef enum logic {RIdle, RStream} rstate_e;

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS][BURST_LEN];

    slot_e                 slot_q [NUM_SLOTS];
    slot_e                 slot_d [NUM_SLOTS];
    wstate_e               wstate_q;
    rstate_e               rstate_q;
    logic [SW-1:0]         wslot_q, rslot_q, free_idx;
    logic [BW-1:0]         wbeat_q, rbeat_q;
    logic                  wr_ready_q, rdone_q, rd_valid_q, rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_SLOTS-1:0]  full_mask_q, full_d;
    logic [CW-1:0]         free_count_q, free_d;
    logic                  free_any, claim, wr_hs, wr_last, req_ready, req_hs, rd_hs, rd_done;
    logic                  rd_load;

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_q[i] == SlotFree) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    assign claim     = (wstate_q == WIdle) && free_any;
    assign wr_hs     = bus.wr_valid && wr_ready_q;
    assign wr_last   = wr_hs && (wbeat_q == LastBeat);
    assign req_ready = (rstate_q == RIdle) && (slot_q[bus.rd_req_slot] == SlotFull);
    assign req_hs    = bus.rd_req_valid && req_ready;
    assign rd_hs     = rd_valid_q && bus.rd_ready;
    assign rd_done   = rd_hs && rd_last_q;
    // Output register doubles as the registered array read; refill whenever it empties or moves.
    assign rd_load   = (rstate_q == RStream) && !rdone_q && (!rd_valid_q || bus.rd_ready);

    // The two FSMs never touch the same slot, so these updates cannot collide.
    always_comb begin
        slot_d = slot_q;
        if (claim)   slot_d[free_idx]        = SlotFilling;
        if (wr_last) slot_d[wslot_q]         = SlotFull;
        if (req_hs)  slot_d[bus.rd_req_slot] = SlotDraining;
        if (rd_done) slot_d[rslot_q]         = SlotFree;
    end

    always_comb begin
        full_d = '0;
        free_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_d[i] == SlotFull) full_d[i] = 1'b1;
            if (slot_d[i] == SlotFree) free_d = free_d + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_hs) mem[wslot_q][wbeat_q] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= SlotFree;
            wstate_q     <= WIdle;
            rstate_q     <= RIdle;
            wslot_q      <= '0;
            wbeat_q      <= '0;
            wr_ready_q   <= 1'b0;
            rslot_q      <= '0;
            rbeat_q      <= '0;
            rdone_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_last_q    <= 1'b0;
            full_mask_q  <= '0;
            free_count_q <= CW'(NUM_SLOTS);
        end else begin
            slot_q       <= slot_d;
            full_mask_q  <= full_d;
            free_count_q <= free_d;

            unique case (wstate_q)
                WIdle: if (claim) begin
                    wslot_q    <= free_idx;
                    wbeat_q    <= '0;
                    wr_ready_q <= 1'b1;
                    wstate_q   <= WFill;
                end
                WFill: if (wr_hs) begin
                    wbeat_q <= wbeat_q + BW'(1);
                    if (wr_last) begin
                        wr_ready_q <= 1'b0;
                        wstate_q   <= WIdle;
                    end
                end
                default: wstate_q <= WIdle;
            endcase

            unique case (rstate_q)
                RIdle: if (req_hs) begin
                    rslot_q  <= bus.rd_req_slot;
                    rbeat_q  <= '0;
                    rdone_q  <= 1'b0;
                    rstate_q <= RStream;
                end
                RStream: begin
                    if (rd_load) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= mem[rslot_q][rbeat_q];
                        rd_last_q  <= (rbeat_q == LastBeat);
                        rdone_q    <= (rbeat_q == LastBeat);
                        rbeat_q    <= rbeat_q + BW'(1);
                    end else if (rd_hs) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                    end
                    if (rd_done) rstate_q <= RIdle;
                end
                default: rstate_q <= RIdle;
            endcase
        end
    end

`ifdef BURST_SLOT_BUFFER_PARITY_EN
    logic mem_par [NUM_SLOTS][BURST_LEN];
    logic rd_perr_q;

    always_ff @(posedge clk) begin
        if (!rst && wr_hs) mem_par[wslot_q][wbeat_q] <= (^bus.wr_data) ^ bus.err_inject;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_perr_q <= 1'b0;
        end else if (rd_load) begin
            rd_perr_q <= (^mem[rslot_q][rbeat_q]) ^ mem_par[rslot_q][rbeat_q];
        end else if (rd_hs) begin
            rd_perr_q <= 1'b0;
        end
    end

    assign bus.rd_parity_err = rd_perr_q;
`endif

    assign bus.wr_ready     = wr_ready_q;
    assign bus.wr_slot_id   = wslot_q;
    assign bus.rd_req_ready = req_ready;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_last      = rd_last_q;
    assign bus.full_mask    = full_mask_q;
    assign bus.free_count   = free_count_q;
endmodule

// File: tb/tb_burst_slot_buffer.sv
// Directed bench for burst_slot_buffer: fill, drain, stalls, slot reuse, held requests, reset.
module tb_burst_slot_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    burst_slot_buffer_if #(.DATA_WIDTH(64), .NUM_SLOTS(4)) bus ();

    burst_slot_buffer #(.DATA_WIDTH(64), .NUM_SLOTS(4), .BURST_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_burst(input logic [63:0] base, input int exp_slot, input int inj);
        int n;
        n = 0;
        while (!bus.wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_wait", 64'(bus.wr_ready), 64'd1);
        check("wr_slot_id", 64'(bus.wr_slot_id), 64'(exp_slot));
        for (int k = 0; k < 8; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 64'(k);
`ifdef BURST_SLOT_BUFFER_PARITY_EN
            bus.err_inject = (k == inj);
`endif
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
`ifdef BURST_SLOT_BUFFER_PARITY_EN
        bus.err_inject = 1'b0;
`endif
        check("full_after_fill", 64'(bus.full_mask[exp_slot]), 64'd1);
        check("wr_ready_gap", 64'(bus.wr_ready), 64'd0);
    endtask

    task automatic drain(input int slot, input logic [63:0] base, input bit toggle,
                         input int perr);
        int n, idx, cyc;
        bit stall;
        logic [63:0] sdata;
        logic slast;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_slot  = 2'(slot);
        bus.rd_ready     = 1'b1;
        n = 0;
        #1;
        while (!bus.rd_req_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_accept", 64'(bus.rd_req_ready), 64'd1);
        @(negedge clk);
        bus.rd_req_valid = 1'b0;
        check("lat_t1_idle", 64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        idx   = 0;
        cyc   = 0;
        stall = 1'b0;
        sdata = '0;
        slast = 1'b0;
        while (idx < 8 && cyc < 200) begin
            bus.rd_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (cyc == 0) check("lat_t2_valid", 64'(bus.rd_valid), 64'd1);
            if (stall) begin
                check("stall_valid", 64'(bus.rd_valid), 64'd1);
                check("stall_data", bus.rd_data, sdata);
                check("stall_last", 64'(bus.rd_last), 64'(slast));
            end
            if (bus.rd_valid && bus.rd_ready) begin
                check("rd_data", bus.rd_data, base + 64'(idx));
                check("rd_last", 64'(bus.rd_last), 64'(idx == 7));
`ifdef BURST_SLOT_BUFFER_PARITY_EN
                check("rd_parity_err", 64'(bus.rd_parity_err), 64'(idx == perr));
`endif
                idx++;
                stall = 1'b0;
            end else if (bus.rd_valid) begin
                stall = 1'b1;
                sdata = bus.rd_data;
                slast = bus.rd_last;
            end else begin
                stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_beats", 64'(idx), 64'd8);
        check("rd_valid_after", 64'(bus.rd_valid), 64'd0);
        bus.rd_ready = 1'b0;
        if (perr > 99) $display("unused perr %0d", perr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.wr_valid     = 1'b0;
        bus.wr_data      = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_slot  = '0;
        bus.rd_ready     = 1'b0;
`ifdef BURST_SLOT_BUFFER_PARITY_EN
        bus.err_inject   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("rst_wr_slot_id", 64'(bus.wr_slot_id), 64'd0);
        check("rst_rd_req_ready", 64'(bus.rd_req_ready), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_rd_data", bus.rd_data, 64'd0);
        check("rst_rd_last", 64'(bus.rd_last), 64'd0);
        check("rst_full_mask", 64'(bus.full_mask), 64'd0);
        check("rst_free_count", 64'(bus.free_count), 64'd4);
        rst = 1'b0;
        @(negedge clk);
        check("claim_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("claim_free_count", 64'(bus.free_count), 64'd3);

        // Slot 0 fill and full-rate drain.
        write_burst(64'h00, 0, -1);
        check("fill0_full_mask", 64'(bus.full_mask), 64'h1);
        check("fill0_free_count", 64'(bus.free_count), 64'd3);
        drain(0, 64'h00, 1'b0, -1);
        check("drain0_full_mask", 64'(bus.full_mask), 64'h0);
        check("drain0_free_count", 64'(bus.free_count), 64'd3);

        // Request slot 1 while it is still filling; held until it turns FULL.
        check("slot1_id", 64'(bus.wr_slot_id), 64'd1);
        for (int k = 0; k < 8; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 64'h10 + 64'(k);
            if (k >= 3) begin
                bus.rd_req_valid = 1'b1;
                bus.rd_req_slot  = 2'd1;
                #1;
                check("req_held", 64'(bus.rd_req_ready), 64'd0);
            end
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        #1;
        check("req_after_full", 64'(bus.rd_req_ready), 64'd1);
        drain(1, 64'h10, 1'b1, -1);

        // Fill every slot; write side must then stall.
        write_burst(64'h40, 0, -1);
        write_burst(64'h50, 1, -1);
        write_burst(64'h20, 2, -1);
        write_burst(64'h30, 3, -1);
        check("all_full_mask", 64'(bus.full_mask), 64'hf);
        check("all_free_count", 64'(bus.free_count), 64'd0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 64'hdead;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_free_wr_ready", 64'(bus.wr_ready), 64'd0);
        end
        bus.wr_valid = 1'b0;

        // Freeing slot 2 lets the write side reclaim it one cycle later.
        drain(2, 64'h20, 1'b0, -1);
        check("freed_full_mask", 64'(bus.full_mask), 64'hb);
        check("freed_free_count", 64'(bus.free_count), 64'd1);
        check("freed_wr_ready", 64'(bus.wr_ready), 64'd0);
        @(negedge clk);
        check("reclaim_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("reclaim_slot_id", 64'(bus.wr_slot_id), 64'd2);
        check("reclaim_free_count", 64'(bus.free_count), 64'd0);

        drain(0, 64'h40, 1'b1, -1);

        // Reset in the middle of streaming slot 3.
        bus.rd_req_valid = 1'b1;
        bus.rd_req_slot  = 2'd3;
        #1;
        check("s3_req_ready", 64'(bus.rd_req_ready), 64'd1);
        @(negedge clk);
        bus.rd_req_valid = 1'b0;
        bus.rd_ready     = 1'b1;
        @(negedge clk);
        check("s3_beat0", bus.rd_data, 64'h30);
        @(negedge clk);
        check("s3_beat1", bus.rd_data, 64'h31);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("mid_rst_full_mask", 64'(bus.full_mask), 64'h0);
        check("mid_rst_free_count", 64'(bus.free_count), 64'd4);
        check("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        bus.rd_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Post-reset operation; beat 5 carries an injected parity error when enabled.
        write_burst(64'h60, 0, 5);
        drain(0, 64'h60, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
